// File: rtl/i2c_scl_gen.sv
// -----------------------------------------------------------------------------
// i2c_scl_gen
//
// Four-phase I2C SCL generator for the DE0-Nano I2C master. Divides clk down
// to 100 kHz, 400 kHz, 1 MHz or a run-time quarter-period, honours slave clock
// stretching, and emits one-cycle phase strobes for the bit engine.
//
// Optional feature macro: I2C_SCL_STRETCH_EN
//   defined   : scl_in is synchronised and HIGH1 waits for SCL to read high
//               (stretch support); unstretched period is 4Q+2 cycles.
//   undefined : scl_in is ignored, HIGH1 always lasts Q cycles, stretching
//               is tied low; period is exactly 4Q cycles.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   CNT_W       width of the quarter-period counter and custom_div
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      request SCL clocking (level)
//   mode        00 = 100 kHz, 01 = 400 kHz, 10 = 1 MHz, 11 = custom_div
//   custom_div  quarter-period in clk cycles for mode 11 (0/1 forced to 2)
//   scl_in      SCL pad readback (asynchronous)
//   scl_oe      1 = pull SCL low, 0 = release
//   fall_stb    one-cycle pulse on entry to LOW1 (SCL driven low)
//   change_stb  one-cycle pulse on entry to LOW2 (SDA may change)
//   rise_stb    one-cycle pulse on entry to HIGH1 (SCL released)
//   sample_stb  one-cycle pulse on entry to HIGH2 (sample SDA)
//   busy        1 whenever the FSM is not in IDLE
//   stretching  1 while released SCL is held low by a slave
//
// State table:
//   state  | meaning
//   IDLE   | SCL released, counter held at 0, waiting for enable
//   LOW1   | first quarter, SCL driven low
//   LOW2   | second quarter, SCL driven low (SDA change point at entry)
//   HIGH1  | third quarter, SCL released; counter waits for SCL to read high
//   HIGH2  | fourth quarter, SCL released (SDA sample point at entry)
// -----------------------------------------------------------------------------
module i2c_scl_gen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] custom_div,
    input  logic             scl_in,
    output logic             scl_oe,
    output logic             fall_stb,
    output logic             change_stb,
    output logic             rise_stb,
    output logic             sample_stb,
    output logic             busy,
    output logic             stretching
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOW1  = 3'd1,
        S_LOW2  = 3'd2,
        S_HIGH1 = 3'd3,
        S_HIGH2 = 3'd4
    } state_t;

    // Quarter-period lengths, truncated integer division of the clock rate.
    localparam logic [CNT_W-1:0] Q_100K = CNT_W'(CLK_HZ / 400_000);
    localparam logic [CNT_W-1:0] Q_400K = CNT_W'(CLK_HZ / 1_600_000);
    localparam logic [CNT_W-1:0] Q_1M   = CNT_W'(CLK_HZ / 4_000_000);
    localparam logic [CNT_W-1:0] Q_MIN  = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] q_reg;
    logic [CNT_W-1:0] q_sel;
    logic [CNT_W-1:0] q_last;
    logic             cnt_last;
    logic             high_adv;

    logic             scl_oe_nxt;
    logic             busy_nxt;
    logic             fall_nxt;
    logic             change_nxt;
    logic             rise_nxt;
    logic             sample_nxt;

    // -------------------------------------------------------------------------
    // Rate selection; only sampled into q_reg on LOW1 entry, so a mode change
    // mid-period never disturbs the period in flight.
    // -------------------------------------------------------------------------
    always_comb begin
        q_sel = Q_100K;
        case (mode)
            2'b00:   q_sel = Q_100K;
            2'b01:   q_sel = Q_400K;
            2'b10:   q_sel = Q_1M;
            default: q_sel = (custom_div < Q_MIN) ? Q_MIN : custom_div;
        endcase
    end

    assign q_last   = q_reg - ONE;
    assign cnt_last = (cnt == q_last);

    // -------------------------------------------------------------------------
    // SCL readback and stretch detection
    // -------------------------------------------------------------------------
`ifdef I2C_SCL_STRETCH_EN
    logic       sync_q1;
    logic       scl_s;
    logic [1:0] high_age;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            scl_s   <= 1'b1;
        end else begin
            sync_q1 <= scl_in;
            scl_s   <= sync_q1;
        end
    end

    // Saturating age of the current HIGH1 visit; 0 in the entry cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_age <= 2'd0;
        end else if (state != S_HIGH1) begin
            high_age <= 2'd0;
        end else if (high_age != 2'd3) begin
            high_age <= high_age + 2'd1;
        end
    end

    assign high_adv = scl_s;

    // The first cycles of HIGH1 always see scl_s low because of the
    // synchronizer; the age gate keeps that normal rise from being flagged.
    assign stretching = (state == S_HIGH1) && !scl_s && (high_age == 2'd3);
`else
    logic unused_scl_in;

    assign unused_scl_in = scl_in;
    assign high_adv      = 1'b1;
    assign stretching    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state, counter and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + ONE;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (enable) begin
                    state_nxt = S_LOW1;
                end
            end
            S_LOW1: begin
                if (cnt_last) begin
                    state_nxt = S_LOW2;
                    cnt_nxt   = '0;
                end
            end
            S_LOW2: begin
                if (cnt_last) begin
                    state_nxt = S_HIGH1;
                    cnt_nxt   = '0;
                end
            end
            S_HIGH1: begin
                if (!high_adv) begin
                    cnt_nxt = cnt;
                end else if (cnt_last) begin
                    state_nxt = S_HIGH2;
                    cnt_nxt   = '0;
                end
            end
            S_HIGH2: begin
                if (cnt_last) begin
                    state_nxt = enable ? S_LOW1 : S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        scl_oe_nxt = (state_nxt == S_LOW1) || (state_nxt == S_LOW2);
        busy_nxt   = (state_nxt != S_IDLE);
        fall_nxt   = (state_nxt == S_LOW1)  && (state != S_LOW1);
        change_nxt = (state_nxt == S_LOW2)  && (state != S_LOW2);
        rise_nxt   = (state_nxt == S_HIGH1) && (state != S_HIGH1);
        sample_nxt = (state_nxt == S_HIGH2) && (state != S_HIGH2);
    end

    // -------------------------------------------------------------------------
    // Registered outputs and quarter-period latch
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_oe     <= 1'b0;
            busy       <= 1'b0;
            fall_stb   <= 1'b0;
            change_stb <= 1'b0;
            rise_stb   <= 1'b0;
            sample_stb <= 1'b0;
        end else begin
            scl_oe     <= scl_oe_nxt;
            busy       <= busy_nxt;
            fall_stb   <= fall_nxt;
            change_stb <= change_nxt;
            rise_stb   <= rise_nxt;
            sample_stb <= sample_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= Q_100K;
        end else if (fall_nxt) begin
            q_reg <= q_sel;
        end
    end

endmodule
